// File: rtl/alu8_arith_logic_core.sv
// 8-bit registered ALU: arithmetic, bitwise logic and shift groups behind a
// group mux, with the result and status flags captured every clock.
module alu8_logic_lane (
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    case (op)
      2'b00:   y = a & b;
      2'b01:   y = a | b;
      2'b10:   y = a ^ b;
      default: y = ~a;
    endcase
  end
endmodule

module alu8_arith_logic_core (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       cin,
  input  logic [3:0] s,
  output logic [7:0] F,
  output logic       CARRY,
  output logic       OVERFLOW,
  output logic       ZERO,
  output logic       A_EQUAL_B,
  output logic       A_GREATER_B,
  output logic       A_SMALLER_B
);
  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {
    GRP_ARITH = 2'b00,
    GRP_RSVD  = 2'b01,
    GRP_LOGIC = 2'b10,
    GRP_SHIFT = 2'b11
  } grp_e;

  grp_e       grp;
  logic [1:0] op;
  logic [7:0] y;
  logic [8:0] sum;
  logic [7:0] f_ar, f_lo, f_sh, f_con;
  logic       ar_carry, ar_ovf;

  assign grp = grp_e'(s[3:2]);
  assign op  = s[1:0];

  // Second operand choice turns one adder into pass/inc, add, sub and dec.
  always_comb begin
    y = 8'h00;
    case (op)
      2'b00:   y = 8'h00;
      2'b01:   y = B;
      2'b10:   y = ~B;
      default: y = 8'hFF;
    endcase
  end

  assign sum      = {1'b0, A} + {1'b0, y} + {8'h00, cin};
  assign f_ar     = sum[7:0];
  assign ar_carry = sum[8];
  assign ar_ovf   = (A[7] == y[7]) && (f_ar[7] != A[7]);

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      alu8_logic_lane u_lane (
        .a  (A[i]),
        .b  (B[i]),
        .op (op),
        .y  (f_lo[i])
      );
    end
  endgenerate

  always_comb begin
    f_sh = 8'h00;
    case (op)
      2'b00:   f_sh = {A[6:0], 1'b0};
      2'b01:   f_sh = {1'b0, A[7:1]};
      2'b10:   f_sh = {A[6:0], A[7]};
      default: f_sh = {A[0], A[7:1]};
    endcase
  end

  always_comb begin
    f_con = 8'h00;
    case (grp)
      GRP_ARITH: f_con = f_ar;
      GRP_LOGIC: f_con = f_lo;
      GRP_SHIFT: f_con = f_sh;
      default:   f_con = 8'h00;
    endcase
  end

  // Arithmetic status is sticky across non-arithmetic ops; compares refresh every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F           <= 8'h00;
      CARRY       <= 1'b0;
      OVERFLOW    <= 1'b0;
      ZERO        <= 1'b0;
      A_EQUAL_B   <= 1'b0;
      A_GREATER_B <= 1'b0;
      A_SMALLER_B <= 1'b0;
    end else begin
      F           <= f_con;
      ZERO        <= (f_con == 8'h00);
      A_EQUAL_B   <= (A == B);
      A_GREATER_B <= (A > B);
      A_SMALLER_B <= (A < B);
      if (grp == GRP_ARITH) begin
        CARRY    <= ar_carry;
        OVERFLOW <= ar_ovf;
      end
    end
  end
endmodule

// File: tb/tb_alu8_arith_logic_core.sv
// Directed-vector bench for alu8_arith_logic_core with hand-computed results.
module tb_alu8_arith_logic_core;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A, B;
  logic       cin;
  logic [3:0] s;
  logic [7:0] F;
  logic       CARRY, OVERFLOW, ZERO, A_EQUAL_B, A_GREATER_B, A_SMALLER_B;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu8_arith_logic_core dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .cin         (cin),
    .s           (s),
    .F           (F),
    .CARRY       (CARRY),
    .OVERFLOW    (OVERFLOW),
    .ZERO        (ZERO),
    .A_EQUAL_B   (A_EQUAL_B),
    .A_GREATER_B (A_GREATER_B),
    .A_SMALLER_B (A_SMALLER_B)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ef, input logic ec, input logic ev,
                         input logic ez, input logic eq, input logic gt, input logic lt);
    chk({tag, ".F"},  F, ef);
    chk({tag, ".C"},  {7'h0, CARRY},       {7'h0, ec});
    chk({tag, ".V"},  {7'h0, OVERFLOW},    {7'h0, ev});
    chk({tag, ".Z"},  {7'h0, ZERO},        {7'h0, ez});
    chk({tag, ".EQ"}, {7'h0, A_EQUAL_B},   {7'h0, eq});
    chk({tag, ".GT"}, {7'h0, A_GREATER_B}, {7'h0, gt});
    chk({tag, ".LT"}, {7'h0, A_SMALLER_B}, {7'h0, lt});
  endtask

  // Drive one vector, clock it in, sample 1ns after the edge.
  task automatic run(input string tag, input logic [3:0] sv, input logic [7:0] a,
                     input logic [7:0] b, input logic c, input logic [7:0] ef,
                     input logic ec, input logic ev, input logic ez,
                     input logic eq, input logic gt, input logic lt);
    s = sv; A = a; B = b; cin = c;
    @(posedge clk);
    #1;
    chk_all(tag, ef, ec, ev, ez, eq, gt, lt);
  endtask

  initial begin
    rst = 1'b1; A = 8'h00; B = 8'h00; cin = 1'b0; s = 4'b0000;
    #2;
    chk_all("rst_async", 8'h00, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_held", 8'h00, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    //   tag        s        A      B      cin  F      C  V  Z  EQ GT LT
    run("add_ovf",  4'b0001, 8'h7F, 8'h01, 0,   8'h80, 0, 1, 0, 0, 1, 0);
    run("sub_eq",   4'b0010, 8'h05, 8'h05, 1,   8'h00, 1, 0, 1, 1, 0, 0);
    run("dec0",     4'b0011, 8'h00, 8'h05, 0,   8'hFF, 0, 0, 0, 0, 0, 1);
    run("add_cv",   4'b0001, 8'h80, 8'h80, 0,   8'h00, 1, 1, 1, 1, 0, 0);
    run("and_hold", 4'b1000, 8'hF0, 8'h3C, 0,   8'h30, 1, 1, 0, 0, 1, 0);
    run("or",       4'b1001, 8'hF0, 8'h3C, 1,   8'hFC, 1, 1, 0, 0, 1, 0);
    run("xor",      4'b1010, 8'hF0, 8'h3C, 0,   8'hCC, 1, 1, 0, 0, 1, 0);
    run("not",      4'b1011, 8'hF0, 8'h3C, 0,   8'h0F, 1, 1, 0, 0, 1, 0);
    run("shl",      4'b1100, 8'h81, 8'h00, 0,   8'h02, 1, 1, 0, 0, 1, 0);
    run("rol",      4'b1110, 8'h81, 8'h00, 0,   8'h03, 1, 1, 0, 0, 1, 0);
    run("ror",      4'b1111, 8'h81, 8'h00, 0,   8'hC0, 1, 1, 0, 0, 1, 0);
    run("shr",      4'b1101, 8'h81, 8'h00, 0,   8'h40, 1, 1, 0, 0, 1, 0);
    run("rsvd",     4'b0100, 8'h12, 8'h34, 1,   8'h00, 1, 1, 1, 0, 0, 1);
    run("inc",      4'b0000, 8'h41, 8'h41, 1,   8'h42, 0, 0, 0, 1, 0, 0);
    run("dec_c",    4'b0011, 8'h10, 8'h20, 1,   8'h10, 1, 0, 0, 0, 0, 1);
    run("sub_brw",  4'b0010, 8'h03, 8'h05, 1,   8'hFE, 0, 0, 0, 0, 0, 1);
    run("add_wrap", 4'b0001, 8'hFF, 8'h00, 1,   8'h00, 1, 0, 1, 0, 1, 0);
    run("inc_ovf",  4'b0000, 8'h7F, 8'h00, 1,   8'h80, 0, 1, 0, 0, 1, 0);

    // Reset landing between edges must clear state without waiting for clk.
    s = 4'b1011; A = 8'h00; B = 8'h01; cin = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_all("rst_mid", 8'h00, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_mid_held", 8'h00, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    run("post_rst", 4'b1011, 8'h00, 8'h01, 0, 8'hFF, 0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
